// File: rtl/pwm_channel.sv
// -----------------------------------------------------------------------------
// pwm_channel
//
// Tick-driven PWM output stage. A free-running counter advances on each
// one-clk tick from the upstream pulse generator. Period and duty are offered
// through a valid/ready handshake into a shadow register and only copied into
// the active registers at a period boundary (or while idle), so the pin never
// shows a truncated or stretched cycle.
//
// Build option:
//   PWM_DEADTIME_EN  adds the complementary pin pwm_out_n with DEAD clk cycles
//                    of both-low dead time around every change of the raw PWM
//                    value. Without it, DEAD is unused and pwm_out is the raw
//                    value delayed by one clk.
//
// Parameters:
//   WIDTH  width of counter, period and duty
//   DEAD   dead time in clk cycles (1..255), used only with PWM_DEADTIME_EN
//
// Ports:
//   clk          system clock
//   rst          asynchronous reset, active-high
//   tick         count enable, one-clk pulse
//   enable       run request, level-sensitive
//   cfg_valid    config offer
//   cfg_ready    config accept; 1 while the shadow register is empty
//   cfg_period   period minus one, in ticks
//   cfg_duty     high time, in ticks
//   pwm_out      PWM output
//   period_done  one-clk pulse after each period wrap
//   pwm_out_n    complementary output (PWM_DEADTIME_EN only)
// -----------------------------------------------------------------------------
module pwm_channel #(
  parameter int WIDTH = 16,
  parameter int DEAD  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             enable,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_period,
  input  logic [WIDTH-1:0] cfg_duty,
  output logic             pwm_out,
  output logic             period_done
`ifdef PWM_DEADTIME_EN
  ,
  output logic             pwm_out_n
`endif
);

  // Elaboration-time parameter sanity check.
  if (WIDTH < 1 || DEAD < 1 || DEAD > 255) begin : g_bad_param
    $error("pwm_channel: WIDTH must be >= 1 and DEAD must be in 1..255");
  end

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_period_act;
  logic [WIDTH-1:0] r_duty_act;
  logic [WIDTH-1:0] r_shadow_period;
  logic [WIDTH-1:0] r_shadow_duty;
  // Stored as "shadow empty" rather than "pending" so cfg_ready is a flop
  // output with no logic in front of the pin.
  logic             r_shadow_empty;
  logic             r_period_done;
  logic             r_pwm_out;

  logic             w_active;
  logic             w_at_end;
  logic             w_wrap;
  logic             w_accept;
  logic             w_transfer;
  logic             w_raw;

  // Running and still requested. Dropping enable mid-period makes this 0 on
  // the stop cycle, which both suppresses the wrap and forces the pin low on
  // the same edge the FSM returns to IDLE.
  assign w_active   = (r_state == RUN) && enable;
  assign w_at_end   = (r_cnt == r_period_act);
  assign w_wrap     = w_active && tick && w_at_end;
  assign w_accept   = cfg_valid && r_shadow_empty;
  // A wrap that coincides with an accept sees the old (empty) shadow, so the
  // fresh config waits for the following wrap.
  assign w_transfer = !r_shadow_empty && ((r_state == IDLE) || w_wrap);
  assign w_raw      = w_active && (r_cnt < r_duty_act);

  // ---------------------------------------------------------------------------
  // State machine
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of its neighbours, independent of the
    // order in which the simulator runs the always blocks.
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    // NOTE: the default assignment on entry means every path assigns
    // w_state_next, so no latch is inferred.
    w_state_next = r_state;
    unique case (r_state)
      // A pending config is transferred first; RUN follows on the next clk.
      IDLE: if (enable && r_shadow_empty) w_state_next = RUN;
      RUN:  if (!enable)                  w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Counter, active config, handshake and period_done
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt          <= '0;
      r_period_act   <= '1;
      r_duty_act     <= '0;
      r_shadow_empty <= 1'b1;
      r_period_done  <= 1'b0;
    end else begin
      if (!w_active) begin
        r_cnt <= '0;
      end else if (tick) begin
        r_cnt <= w_at_end ? '0 : r_cnt + WIDTH'(1);
      end

      // Transfer only ever happens with the counter at (or about to be) 0,
      // so the counter can never be left above a shorter new period.
      if (w_transfer) begin
        r_period_act <= r_shadow_period;
        r_duty_act   <= r_shadow_duty;
      end

      // Accept needs an empty shadow and transfer needs a full one, so the
      // two can never fire in the same cycle.
      if (w_accept) begin
        r_shadow_empty <= 1'b0;
      end else if (w_transfer) begin
        r_shadow_empty <= 1'b1;
      end

      r_period_done <= w_wrap;
    end
  end

  // NOTE: the shadow data registers have no reset; they are only read after
  // an accept has loaded them, and the empty flag guarding them is reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_shadow_period <= cfg_period;
      r_shadow_duty   <= cfg_duty;
    end
  end

  // ---------------------------------------------------------------------------
  // Output stage
  // ---------------------------------------------------------------------------
`ifdef PWM_DEADTIME_EN
  logic       r_raw_q;
  logic [7:0] r_dead;
  logic       r_pwm_out_n;

  // Any change of raw loads the dead-time counter with both pins low. The
  // newly active pin is driven when the counter is on its last count, which
  // puts the rising edge DEAD+1 clks after raw changed. A further change
  // during dead time simply reloads the counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_raw_q     <= 1'b0;
      r_dead      <= '0;
      r_pwm_out   <= 1'b0;
      r_pwm_out_n <= 1'b0;
    end else if (w_raw != r_raw_q) begin
      r_raw_q     <= w_raw;
      r_dead      <= 8'(DEAD);
      r_pwm_out   <= 1'b0;
      r_pwm_out_n <= 1'b0;
    end else if (r_dead > 8'd1) begin
      r_dead      <= r_dead - 8'd1;
      r_pwm_out   <= 1'b0;
      r_pwm_out_n <= 1'b0;
    end else begin
      r_dead      <= '0;
      r_pwm_out   <= w_raw;
      // Gated by w_active so both pins stay low in IDLE.
      r_pwm_out_n <= w_active && !w_raw;
    end
  end

  assign pwm_out_n = r_pwm_out_n;
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pwm_out <= 1'b0;
    end else begin
      r_pwm_out <= w_raw;
    end
  end
`endif

  assign pwm_out     = r_pwm_out;
  assign period_done = r_period_done;
  assign cfg_ready   = r_shadow_empty;

endmodule

// File: tb/tb_pwm_channel.sv
// -----------------------------------------------------------------------------
// tb_pwm_channel
//
// Directed self-checking bench for pwm_channel (WIDTH=16, DEAD=4). Outputs are
// sampled 1 time unit after each rising clk edge; k below numbers the edges
// after the one that moved the DUT into RUN. Expected values are derived by
// hand from the block's behaviour (pwm_out lags the counter by one clk).
// -----------------------------------------------------------------------------
module tb_pwm_channel;

  logic        clk;
  logic        rst;
  logic        tick;
  logic        enable;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [15:0] cfg_period;
  logic [15:0] cfg_duty;
  logic        pwm_out;
  logic        period_done;
`ifdef PWM_DEADTIME_EN
  logic        pwm_out_n;
`endif

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  pwm_channel #(
    .WIDTH(16),
    .DEAD (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .enable     (enable),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_period (cfg_period),
    .cfg_duty   (cfg_duty),
    .pwm_out    (pwm_out),
    .period_done(period_done)
`ifdef PWM_DEADTIME_EN
    ,
    .pwm_out_n  (pwm_out_n)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One clk with tick driven to t, then sample point 1 unit after the edge.
  task automatic cycle(input bit t);
    tick = t;
    @(posedge clk);
    #1;
    tick = 1'b0;
  endtask

  // Offer a config while the shadow is known to be empty, then let it land.
  task automatic load_idle(input logic [15:0] p, input logic [15:0] d);
    check("load_ready", cfg_ready, 1'b1);
    cfg_period = p;
    cfg_duty   = d;
    cfg_valid  = 1'b1;
    cycle(1'b0);
    cfg_valid  = 1'b0;
    check("ready_after_accept", cfg_ready, 1'b0);
    cycle(1'b0);
    check("ready_after_idle_xfer", cfg_ready, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    tick       = 1'b0;
    enable     = 1'b0;
    cfg_valid  = 1'b0;
    cfg_period = '0;
    cfg_duty   = '0;
    cycle(1'b0);
    cycle(1'b0);
    rst = 1'b0;

    // ---- Reset then idle ----------------------------------------------------
    check("rst_pwm", pwm_out, 1'b0);
    check("rst_ready", cfg_ready, 1'b1);
    check("rst_pd", period_done, 1'b0);
    check("rst_cnt", dut.r_cnt == 16'd0, 1'b1);
`ifdef PWM_DEADTIME_EN
    check("rst_pwm_n", pwm_out_n, 1'b0);
`endif
    for (int k = 1; k <= 8; k++) begin
      cycle(k % 2 == 1);
      check($sformatf("idle_pwm_k%0d", k), pwm_out, 1'b0);
      check($sformatf("idle_pd_k%0d", k), period_done, 1'b0);
    end

`ifndef PWM_DEADTIME_EN
    // ---- Basic 25% PWM, then glitch-free update to 75% ----------------------
    // period=3, duty=1, tick every 4 clks: 4 high / 12 low, period_done every
    // 16 clks. duty=3 is offered at k=38 (cnt=1); the period ending at k=48
    // stays 25%, the next one (k=49..64) is 12 high / 4 low.
    load_idle(16'd3, 16'd1);
    enable = 1'b1;
    cycle(1'b0);
    check("run_entry_pwm", pwm_out, 1'b0);
    cfg_period = 16'd3;
    cfg_duty   = 16'd3;
    for (int k = 1; k <= 64; k++) begin
      cfg_valid = (k == 38);
      cycle(k % 4 == 0);
      cfg_valid = 1'b0;
      check($sformatf("b_pwm_k%0d", k), pwm_out, ((k - 1) % 16) < ((k <= 48) ? 4 : 12));
      check($sformatf("b_pd_k%0d", k), period_done, k % 16 == 0);
      check($sformatf("b_ready_k%0d", k), cfg_ready, !(k >= 38 && k <= 47));
    end

    // ---- Duty boundaries: duty=0 then duty=9 with period=7, tick every clk --
    enable = 1'b0;
    cycle(1'b0);
    check("stop_pwm", pwm_out, 1'b0);
    check("stop_pd", period_done, 1'b0);
    load_idle(16'd7, 16'd0);
    enable = 1'b1;
    cycle(1'b0);
    cfg_duty = 16'd9;
    for (int k = 1; k <= 40; k++) begin
      cfg_valid = (k == 17);
      cycle(1'b1);
      cfg_valid = 1'b0;
      // duty=9 accepted at k=17, applied at the wrap on k=24.
      check($sformatf("d_pwm_k%0d", k), pwm_out, k >= 25);
      check($sformatf("d_pd_k%0d", k), period_done, k % 8 == 0);
    end

    // ---- Mid-period stop at cnt=2 -------------------------------------------
    cycle(1'b1);
    cycle(1'b1);
    check("pre_stop_cnt2", dut.r_cnt == 16'd2, 1'b1);
    check("pre_stop_pwm", pwm_out, 1'b1);
    enable = 1'b0;
    cycle(1'b1);
    check("midstop_pwm", pwm_out, 1'b0);
    check("midstop_pd", period_done, 1'b0);
    check("midstop_cnt", dut.r_cnt == 16'd0, 1'b1);
    cycle(1'b1);
    check("midstop_pd2", period_done, 1'b0);
    check("midstop_pwm2", pwm_out, 1'b0);

    // ---- Async reset between edges while pwm_out=1 --------------------------
    enable = 1'b1;
    cycle(1'b0);
    cycle(1'b1);
    check("prerst_pwm", pwm_out, 1'b1);
    check("prerst_cnt1", dut.r_cnt == 16'd1, 1'b1);
    #3;
    rst    = 1'b1;
    enable = 1'b0;
    #1;
    check("async_rst_pwm", pwm_out, 1'b0);
    check("async_rst_cnt", dut.r_cnt == 16'd0, 1'b1);
    check("async_rst_ready", cfg_ready, 1'b1);
    #1;
    rst = 1'b0;

    // ---- period=0: every tick wraps -----------------------------------------
    load_idle(16'd0, 16'd1);
    enable = 1'b1;
    cycle(1'b0);
    for (int k = 1; k <= 8; k++) begin
      cycle(k % 2 == 1);
      check($sformatf("p0_pwm_k%0d", k), pwm_out, 1'b1);
      check($sformatf("p0_pd_k%0d", k), period_done, k % 2 == 1);
    end
    enable = 1'b0;
    cycle(1'b0);
    check("p0_stop_pwm", pwm_out, 1'b0);
`else
    // ---- Dead time, DEAD=4, period=7, duty=4 --------------------------------
    // Tick every clk: raw toggles every 4 clks, dead time never expires, so
    // both pins stay low.
    load_idle(16'd7, 16'd4);
    enable = 1'b1;
    cycle(1'b0);
    for (int k = 1; k <= 16; k++) begin
      cycle(1'b1);
      check($sformatf("dt1_pwm_k%0d", k), pwm_out, 1'b0);
      check($sformatf("dt1_pwmn_k%0d", k), pwm_out_n, 1'b0);
      check($sformatf("dt1_pd_k%0d", k), period_done, k % 8 == 0);
    end
    enable = 1'b0;
    repeat (6) cycle(1'b0);
    check("dt_idle_pwm", pwm_out, 1'b0);
    check("dt_idle_pwmn", pwm_out_n, 1'b0);
    // Tick every 2 clks: raw rises at k=0,16 and falls at k=8,24; each pin
    // rises 5 clks after the raw change that activates it.
    enable = 1'b1;
    cycle(1'b0);
    for (int k = 1; k <= 32; k++) begin
      cycle(k % 2 == 0);
      check($sformatf("dt2_pwm_k%0d", k), pwm_out, (k % 16 >= 5) && (k % 16 <= 8));
      check($sformatf("dt2_pwmn_k%0d", k), pwm_out_n, (k % 16 >= 13) || (k % 16 == 0));
      check($sformatf("dt2_overlap_k%0d", k), pwm_out && pwm_out_n, 1'b0);
    end
    enable = 1'b0;
    cycle(1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pwm_channel.md
Name: pwm_channel

Overview:
- Tick-driven PWM output stage, downstream of the pulse generator. It consumes the generator's one-clock tick (q) as its count enable and drives a board pin.
- Period and duty are loaded through a valid/ready handshake into a shadow register. The shadow is applied only at a period boundary, so the output never shows a glitched cycle.
- This block replaces the bare toggle flops used today for square-wave pins.

Parameters:
- WIDTH, 16, width of the counter, period and duty.
- DEAD, 4, dead-time in clk cycles. Used only with PWM_DEADTIME_EN; legal range 1..255.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-high
- tick  input  1  count enable: one-clk pulse from the pulse generator
- enable  input  1  run request; level-sensitive
- cfg_valid  input  1  config offer
- cfg_ready  output  1  config accept; 1 when the shadow register is empty
- cfg_period  input  WIDTH  period minus one, in ticks
- cfg_duty  input  WIDTH  high time, in ticks
- pwm_out  output  1  PWM output
- period_done  output  1  one-clk pulse at each period wrap
- pwm_out_n  output  1  complementary output; present only with PWM_DEADTIME_EN

Behaviour:
- Reset (asynchronous, immediate):
  - state=IDLE, cnt=0, period_act=all ones, duty_act=0, pending=0.
  - pwm_out=0, period_done=0, cfg_ready=1, pwm_out_n=0.
- cfg_ready = ~pending, driven from a register with no combinational path from cfg_valid.
- Config accept (cfg_valid && cfg_ready): shadow<= {cfg_period, cfg_duty}; pending<=1.
- Shadow transfer (shadow->active, pending<=0):
  - in RUN, on the wrap cycle;
  - in IDLE, on the first clk after pending=1.
- Accept and wrap in the same cycle: the wrap uses the old state (pending=0, nothing transferred). The new config waits for the next wrap.
- State machine:
  - IDLE: cnt held at 0. Moves to RUN on the clk where enable=1 and pending=0. If pending=1, the transfer happens first and RUN is entered the following clk.
  - RUN: on tick, cnt<=(cnt==period_act) ? 0 : cnt+1. Period length is period_act+1 ticks.
  - RUN -> IDLE: on the clk where enable=0, mid-period allowed. cnt<=0 and pwm_out<=0 on that edge. No period_done pulse.
- Wrap: tick && cnt==period_act in RUN. period_done=1 for exactly the following clk.
- Raw PWM value: raw = (state==RUN) && (cnt < duty_act), unsigned compare.
- pwm_out <= raw on every clk edge, so pwm_out lags cnt by one clk.
- Duty boundaries:
  - duty_act=0: output constant low.
  - duty_act > period_act: output constant high while running (100%).
- tick ignored in IDLE. tick asserted on consecutive clks is legal; each asserted clk counts one.
- period_act=0: every tick wraps, and period_done follows each tick.
- No arithmetic overflow: cnt never exceeds period_act. Comparisons are WIDTH-bit unsigned.

Optional Feature:
- Macro: PWM_DEADTIME_EN.
- Defined:
  - pwm_out_n exists.
  - Any change of raw forces both outputs low for DEAD clk cycles; then the newly active output (pwm_out if raw=1, else pwm_out_n) goes high.
  - If raw changes again during dead-time, the dead-time counter restarts.
  - In IDLE both outputs are 0.
  - pwm_out rises DEAD+1 clks after cnt enters the high region.
- Not defined:
  - No pwm_out_n port and no dead-time logic. DEAD is unused.
  - pwm_out follows raw with one clk latency as above.

Test Plan:
- Reset then idle:
  - Stimulus: rst pulse, enable=0, ticks running.
  - Required: pwm_out=0, cfg_ready=1, period_done never asserts.
- Basic 25% PWM:
  - Stimulus: load period=3, duty=1; enable=1; tick every 4 clks.
  - Required: pwm_out high 4 clks, low 12 clks, repeating. period_done pulses every 16 clks.
- Glitch-free update:
  - Stimulus: running period=3, duty=1; offer duty=3 mid-period.
  - Required: cfg_ready drops the clk after the accept. The current period finishes at 25%; the next is 75%. cfg_ready returns to 1 the clk after the wrap.
- Duty boundaries:
  - Stimulus: duty=0, then duty=9 with period=7.
  - Required: constant 0, then constant 1 across all ticks. period_done still pulses every 8 ticks.
- Mid-period stop and async reset:
  - Stimulus: drop enable at cnt=2. Later, assert rst between clk edges while pwm_out=1.
  - Required: pwm_out=0 on the next edge with no period_done. On rst, pwm_out=0 immediately and cnt=0.
- With PWM_DEADTIME_EN, DEAD=4:
  - Stimulus: period=7, duty=4, tick every clk.
  - Required: pwm_out and pwm_out_n are never 1 simultaneously, and each rising edge comes exactly 5 clks after the raw transition.
